hand_packet_tx: RTL and testbench

//  Camera-2 side of the inter-board hand-coordinate link. Captures top/bottom hand (x,y) on a

---
 rtl/hand_link_pkg.sv | 24 ++
 rtl/hand_packet_tx_if.sv | 24 ++
 rtl/uart_tx_byte.sv | 99 +++++++++
 rtl/hand_packet_tx.sv | 160 ++++++++++++++++
 tb/tb_hand_packet_tx.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hand_link_pkg.sv
// Shared definitions for the inter-board hand-coordinate link (camera-2 transmitter and
// camera-1 unpacker). Build option HAND_TX_CHECKSUM_EN appends an XOR checksum byte.
package hand_link_pkg;

    localparam logic [7:0]  HDR_BYTE    = 8'hFF;
    localparam int unsigned HDR_LEN     = 3;
    localparam int unsigned PAYLOAD_LEN = 6;
`ifdef HAND_TX_CHECKSUM_EN
    localparam int unsigned PKT_LEN     = HDR_LEN + PAYLOAD_LEN + 1;
`else
    localparam int unsigned PKT_LEN     = HDR_LEN + PAYLOAD_LEN;
`endif

    typedef enum logic [1:0] {StIdle, StLoad, StSend} pkt_state_e;

    typedef enum logic [1:0] {UartIdle, UartStart, UartData, UartStop} uart_state_e;

    // Payload bytes MSB first: x_top[11:4], {x_top[3:0], y_top[11:8]}, y_top[7:0], ...
    function automatic logic [47:0] pack_hand(input logic [11:0] xt, input logic [11:0] yt,
                                              input logic [11:0] xb, input logic [11:0] yb);
        return {xt, yt, xb, yb};
    endfunction

endpackage

// File: rtl/hand_packet_tx_if.sv
// Request/coordinate inputs and UART/status outputs of the hand packet transmitter.
interface hand_packet_tx_if;

    logic        send_in;
    logic [11:0] x_top_in;
    logic [11:0] y_top_in;
    logic [11:0] x_bot_in;
    logic [11:0] y_bot_in;
    logic        tx_out;
    logic        busy_out;
    logic        done_out;
    logic [7:0]  drop_cnt_out;

    modport master (
        output send_in, x_top_in, y_top_in, x_bot_in, y_bot_in,
        input  tx_out, busy_out, done_out, drop_cnt_out
    );

    modport slave (
        input  send_in, x_top_in, y_top_in, x_bot_in, y_bot_in,
        output tx_out, busy_out, done_out, drop_cnt_out
    );

endinterface

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serialiser. byte_done_out marks the last cycle of the stop bit; a start_in
// in that cycle is accepted so the next start bit follows with no idle gap.
module uart_tx_byte
    import hand_link_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 564
) (
    input  logic       clk_in,
    input  logic       rst_in_n,
    input  logic       start_in,
    input  logic [7:0] data_in,
    output logic       tx_out,
    output logic       busy_out,
    output logic       byte_done_out
);
    localparam int unsigned     CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    uart_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic             w_bit_end;
    logic             w_accept;

    assign w_bit_end     = (r_cnt == CNT_LAST);
    assign byte_done_out = (r_state == UartStop) && w_bit_end;
    assign busy_out      = (r_state != UartIdle) && !byte_done_out;
    assign w_accept      = start_in && !busy_out;

    // Serialiser state, baud counter, bit index and shift data
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_state <= UartIdle;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Next-state: each bit holds for BAUD_DIV cycles
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_bit_end ? '0 : r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_data_nxt  = r_data;
        unique case (r_state)
            UartIdle: begin
                w_cnt_nxt = '0;
                if (w_accept) begin
                    w_state_nxt = UartStart;
                    w_data_nxt  = data_in;
                end
            end
            UartStart: begin
                if (w_bit_end) begin
                    w_state_nxt = UartData;
                    w_bit_nxt   = '0;
                end
            end
            UartData: begin
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
                        w_state_nxt = UartStop;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            UartStop: begin
                if (w_bit_end) begin
                    if (w_accept) begin
                        w_state_nxt = UartStart;
                        w_data_nxt  = data_in;
                    end else begin
                        w_state_nxt = UartIdle;
                    end
                end
            end
            default: w_state_nxt = UartIdle;
        endcase
    end

    // Line level decoded from state; idle and stop are high
    always_comb begin
        tx_out = 1'b1;
        unique case (r_state)
            UartStart: tx_out = 1'b0;
            UartData:  tx_out = r_data[r_bit];
            default:   tx_out = 1'b1;
        endcase
    end

endmodule

// File: rtl/hand_packet_tx.sv
// Camera-2 hand-coordinate packet transmitter: captures four coordinates on send_in and sends
// FF FF FF + 6 payload bytes over UART 8N1. Build option HAND_TX_CHECKSUM_EN appends a 10th
// byte, the XOR of the six payload bytes.
module hand_packet_tx
    import hand_link_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 564
) (
    input  logic            clk_in,
    input  logic            rst_in_n,
    hand_packet_tx_if.slave bus
);
    localparam logic [3:0] IDX_LAST = 4'(PKT_LEN - 1);

    pkt_state_e  r_state, w_state_nxt;
    logic [3:0]  r_idx, w_idx_nxt;
    logic [47:0] r_payload, w_payload_nxt;
    logic [47:0] r_pend_buf, w_pend_buf_nxt;
    logic        r_pend, w_pend_nxt;
    logic [7:0]  r_drop, w_drop_nxt;
    logic        r_done, w_done_nxt;
    logic        w_start;
    logic [7:0]  w_data;
    logic        w_tx;
    logic        w_uart_busy;
    logic        w_byte_done;
    logic [47:0] w_capture;
    logic        w_last;
    logic        w_take_now;
    logic [7:0]  w_drop_inc;
    logic [3:0]  w_idx_inc;

    function automatic logic [7:0] pkt_byte(input logic [47:0] pl, input logic [3:0] idx);
        logic [7:0] b;
        b = HDR_BYTE;
        case (idx)
            4'd3:    b = pl[47:40];
            4'd4:    b = pl[39:32];
            4'd5:    b = pl[31:24];
            4'd6:    b = pl[23:16];
            4'd7:    b = pl[15:8];
            4'd8:    b = pl[7:0];
`ifdef HAND_TX_CHECKSUM_EN
            4'd9:    b = pl[47:40] ^ pl[39:32] ^ pl[31:24] ^ pl[23:16] ^ pl[15:8] ^ pl[7:0];
`endif
            default: b = HDR_BYTE;
        endcase
        return b;
    endfunction

    assign w_capture  = pack_hand(bus.x_top_in, bus.y_top_in, bus.x_bot_in, bus.y_bot_in);
    assign w_last     = (r_idx == IDX_LAST);
    assign w_drop_inc = (r_drop == 8'hFF) ? r_drop : r_drop + 8'd1;
    assign w_idx_inc  = r_idx + 4'd1;

    assign bus.tx_out       = w_tx;
    assign bus.busy_out     = (r_state != StIdle);
    assign bus.done_out     = r_done;
    assign bus.drop_cnt_out = r_drop;

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk_in        (clk_in),
        .rst_in_n      (rst_in_n),
        .start_in      (w_start),
        .data_in       (w_data),
        .tx_out        (w_tx),
        .busy_out      (w_uart_busy),
        .byte_done_out (w_byte_done)
    );

    // Packet state, payload/pending buffers and status registers
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_state    <= StIdle;
            r_idx      <= '0;
            r_payload  <= '0;
            r_pend_buf <= '0;
            r_pend     <= 1'b0;
            r_drop     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_payload  <= w_payload_nxt;
            r_pend_buf <= w_pend_buf_nxt;
            r_pend     <= w_pend_nxt;
            r_drop     <= w_drop_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Packet sequencing. Later bytes (and a pending packet) are handed to the serialiser in its
    // final stop cycle so consecutive bytes and packets run back-to-back.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_payload_nxt  = r_payload;
        w_pend_buf_nxt = r_pend_buf;
        w_pend_nxt     = r_pend;
        w_drop_nxt     = r_drop;
        w_done_nxt     = 1'b0;
        w_start        = 1'b0;
        w_data         = HDR_BYTE;
        w_take_now     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.send_in) begin
                    w_payload_nxt = w_capture;
                    w_idx_nxt     = '0;
                    w_state_nxt   = StLoad;
                end
            end
            StLoad: begin
                if (!w_uart_busy) begin
                    w_start     = 1'b1;
                    w_data      = pkt_byte(r_payload, r_idx);
                    w_state_nxt = StSend;
                end
            end
            StSend: begin
                if (w_byte_done) begin
                    if (!w_last) begin
                        w_start   = 1'b1;
                        w_idx_nxt = w_idx_inc;
                        w_data    = pkt_byte(r_payload, w_idx_inc);
                    end else begin
                        w_done_nxt = 1'b1;
                        if (bus.send_in || r_pend) begin
                            // Next packet starts with a header byte, so the new payload can
                            // land one cycle after its first byte is handed over.
                            w_take_now    = 1'b1;
                            w_start       = 1'b1;
                            w_data        = HDR_BYTE;
                            w_idx_nxt     = '0;
                            w_pend_nxt    = 1'b0;
                            w_payload_nxt = bus.send_in ? w_capture : r_pend_buf;
                        end else begin
                            w_state_nxt = StIdle;
                        end
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        // Requests while busy go to the 1-deep pending buffer; latest wins
        if (bus.send_in && (r_state != StIdle)) begin
            if (r_pend) begin
                w_drop_nxt = w_drop_inc;
            end
            if (!w_take_now) begin
                w_pend_buf_nxt = w_capture;
                w_pend_nxt     = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hand_packet_tx.sv
// Self-checking bench for hand_packet_tx with BAUD_DIV=4: UART monitor decodes tx_out,
// table-driven packets plus hand-written pending/reset/saturation sequences.
module tb_hand_packet_tx;
    import hand_link_pkg::*;

    localparam int unsigned B       = 4;
`ifdef HAND_TX_CHECKSUM_EN
    localparam int          PKT     = 10;
`else
    localparam int          PKT     = 9;
`endif
    localparam int          PKT_CYC = PKT * 10 * B;

    typedef struct {
        logic [11:0] xt;
        logic [11:0] yt;
        logic [11:0] xb;
        logic [11:0] yb;
        logic [47:0] pay;
    } vec_t;

    logic clk;
    logic rst_n;
    hand_packet_tx_if ifc ();

    hand_packet_tx #(
        .BAUD_DIV (B)
    ) dut (
        .clk_in   (clk),
        .rst_in_n (rst_n),
        .bus      (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // UART monitor and status trackers, sampled on the falling edge
    logic [7:0] rx_q[$];
    int         rx_start_q[$];
    logic       rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = '0;
    logic       bit_val = 1'b1;
    int         glitch_cnt = 0;
    int         stop_err = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         rise_cyc = 0;
    logic       busy_prev = 1'b0;
    logic       busy_at_done = 1'b0;

    always @(negedge clk) begin
        busy_prev <= ifc.busy_out;
        if (ifc.busy_out && !busy_prev) rise_cyc <= cyc;
        if (ifc.done_out) begin
            done_cnt     <= done_cnt + 1;
            done_cyc     <= cyc;
            busy_at_done <= ifc.busy_out;
        end
        if (!rst_n) begin
            rx_busy <= 1'b0;
        end else if (!rx_busy) begin
            if (ifc.tx_out == 1'b0) begin
                rx_busy <= 1'b1;
                rx_cnt  <= 1;
                bit_val <= 1'b0;
                rx_start_q.push_back(cyc);
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt % B == 0) bit_val <= ifc.tx_out;
            else if (ifc.tx_out != bit_val) glitch_cnt <= glitch_cnt + 1;
            if (rx_cnt % B == B / 2) begin
                if (rx_cnt / B >= 1 && rx_cnt / B <= 8) begin
                    rx_sh <= {ifc.tx_out, rx_sh[7:1]};
                end else if (rx_cnt / B == 9) begin
                    if (ifc.tx_out != 1'b1) stop_err <= stop_err + 1;
                    rx_q.push_back(rx_sh);
                    rx_busy <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [47:0] pay, input int i);
        logic [7:0] c;
        if (i < 3) return 8'hFF;
        if (i < 9) return pay[8*(8-i) +: 8];
        c = 8'h00;
        for (int k = 0; k < 6; k++) c = c ^ pay[8*k +: 8];
        return c;
    endfunction

    task automatic check_packet(input int base, input logic [47:0] pay, input string tag);
        for (int i = 0; i < PKT; i++) begin
            logic [7:0] got;
            got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
            check($sformatf("%s byte%0d", tag, i), {24'd0, got}, {24'd0, exp_byte(pay, i)});
        end
    endtask

    task automatic drive(input vec_t v);
        ifc.x_top_in = v.xt;
        ifc.y_top_in = v.yt;
        ifc.x_bot_in = v.xb;
        ifc.y_bot_in = v.yb;
    endtask

    int send_cyc = 0;

    task automatic send(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        ifc.send_in = 1'b1;
        send_cyc    = cyc;
        @(posedge clk);
        #1;
        ifc.send_in = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input bit scramble,
                             input string tag);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (scramble) begin
                ifc.x_top_in = 12'($urandom);
                ifc.y_top_in = 12'($urandom);
                ifc.x_bot_in = 12'($urandom);
                ifc.y_bot_in = 12'($urandom);
            end
        end
        if (done_cnt < target) begin
            n_checks++;
            n_err++;
            $display("FAIL %s timeout: done count %0d required %0d", tag, done_cnt, target);
        end
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_start_q.delete();
    endtask

    vec_t vecs[4];
    int   d0;
    int   n;
    int   bad;
    int   dcyc;

    initial begin
        vecs[0] = '{12'h123, 12'h045, 12'h3FF, 12'h2FF, 48'h12_30_45_3F_F2_FF};
        vecs[1] = '{12'h000, 12'h000, 12'h000, 12'h000, 48'h00_00_00_00_00_00};
        vecs[2] = '{12'h3FF, 12'h2FF, 12'h000, 12'h000, 48'h3F_F2_FF_00_00_00};
        vecs[3] = '{12'h2A5, 12'h1C3, 12'h155, 12'h0AA, 48'h2A_51_C3_15_50_AA};

        rst_n       = 1'b0;
        ifc.send_in = 1'b0;
        drive(vecs[1]);
        repeat (3) @(posedge clk);
        #1;
        check("reset tx", {31'd0, ifc.tx_out}, 32'd1);
        check("reset busy", {31'd0, ifc.busy_out}, 32'd0);
        check("reset done", {31'd0, ifc.done_out}, 32'd0);
        check("reset drop", {24'd0, ifc.drop_cnt_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Table: single packets; vector 3 scrambles inputs while its packet is in flight
        for (int v = 0; v < 4; v++) begin
            clear_rx();
            d0 = done_cnt;
            send(vecs[v]);
            wait_done(d0 + 1, 2 * PKT_CYC, (v == 3), $sformatf("vec%0d", v));
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("vec%0d nbytes", v), rx_q.size(), PKT);
            check_packet(0, vecs[v].pay, $sformatf("vec%0d", v));
            check($sformatf("vec%0d start latency", v),
                  (rx_start_q.size() > 0) ? rx_start_q[0] - send_cyc : -1, 2);
            check($sformatf("vec%0d busy latency", v), rise_cyc - send_cyc, 1);
            check($sformatf("vec%0d start-to-done", v),
                  (rx_start_q.size() > 0) ? done_cyc - rx_start_q[0] : -1, PKT_CYC);
            check($sformatf("vec%0d busy at done", v), {31'd0, busy_at_done}, 32'd0);
            check($sformatf("vec%0d done pulses", v), done_cnt - d0, 1);
            check($sformatf("vec%0d busy idle", v), {31'd0, ifc.busy_out}, 32'd0);
        end

        // A in flight, B and C queued: A then C back-to-back, one drop
        clear_rx();
        d0 = done_cnt;
        send(vecs[0]);
        repeat (50) @(posedge clk);
        send(vecs[1]);
        repeat (50) @(posedge clk);
        send(vecs[2]);
        wait_done(d0 + 2, 3 * PKT_CYC, 1'b0, "abc");
        repeat (3) @(posedge clk);
        #1;
        check("abc nbytes", rx_q.size(), 2 * PKT);
        check_packet(0, vecs[0].pay, "abc A");
        check_packet(PKT, vecs[2].pay, "abc C");
        check("abc drop", {24'd0, ifc.drop_cnt_out}, 32'd1);
        bad = 0;
        for (int i = 1; i < rx_start_q.size(); i++) begin
            if (rx_start_q[i] - rx_start_q[i-1] != 10 * B) bad++;
        end
        check("abc byte spacing", bad, 0);
        check("abc done pulses", done_cnt - d0, 2);

        // send_in in the done cycle: no drop, sent straight away
        clear_rx();
        d0 = done_cnt;
        send(vecs[1]);
        n = 0;
        while (ifc.done_out !== 1'b1 && n < 2 * PKT_CYC) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (ifc.done_out !== 1'b1) begin
            n_checks++;
            n_err++;
            $display("FAIL donecyc timeout: done_out never seen");
        end
        drive(vecs[3]);
        ifc.send_in = 1'b1;
        dcyc        = cyc;
        @(posedge clk);
        #1;
        ifc.send_in = 1'b0;
        wait_done(d0 + 2, 3 * PKT_CYC, 1'b0, "donecyc");
        repeat (3) @(posedge clk);
        #1;
        check("donecyc nbytes", rx_q.size(), 2 * PKT);
        check_packet(0, vecs[1].pay, "donecyc first");
        check_packet(PKT, vecs[3].pay, "donecyc second");
        check("donecyc drop", {24'd0, ifc.drop_cnt_out}, 32'd1);
        check("donecyc start latency",
              (rx_start_q.size() > PKT) ? rx_start_q[PKT] - dcyc : -1, 2);

        // Reset during byte 5
        clear_rx();
        send(vecs[0]);
        n = 0;
        while (rx_q.size() < 4 && n < 2 * PKT_CYC) begin
            @(posedge clk);
            n++;
        end
        if (rx_q.size() < 4) begin
            n_checks++;
            n_err++;
            $display("FAIL midreset timeout: bytes %0d required 4", rx_q.size());
        end
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset tx", {31'd0, ifc.tx_out}, 32'd1);
        check("midreset busy", {31'd0, ifc.busy_out}, 32'd0);
        check("midreset drop", {24'd0, ifc.drop_cnt_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        clear_rx();
        d0 = done_cnt;
        send(vecs[0]);
        wait_done(d0 + 1, 2 * PKT_CYC, 1'b0, "postreset");
        repeat (3) @(posedge clk);
        #1;
        check("postreset nbytes", rx_q.size(), PKT);
        check_packet(0, vecs[0].pay, "postreset");

        // Drop counter saturation: send_in held for 270 cycles during one packet
        clear_rx();
        d0 = done_cnt;
        send(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        drive(vecs[2]);
        ifc.send_in = 1'b1;
        repeat (270) @(posedge clk);
        #1;
        ifc.send_in = 1'b0;
        check("sat drop", {24'd0, ifc.drop_cnt_out}, 32'd255);
        wait_done(d0 + 2, 3 * PKT_CYC, 1'b0, "sat");
        repeat (3) @(posedge clk);
        #1;
        check("sat nbytes", rx_q.size(), 2 * PKT);
        check_packet(PKT, vecs[2].pay, "sat latest");
        check("sat drop held", {24'd0, ifc.drop_cnt_out}, 32'd255);
        check("sat busy idle", {31'd0, ifc.busy_out}, 32'd0);

        check("bit stability", glitch_cnt, 0);
        check("stop bits", stop_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
